branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences the branch target buffer and the front end.
- Carries each fetch-time prediction alongside its instruction from F to EX, compares it with the resolved outcome, and issues a single registered redirect plus pipeline flush on a mispredict.
- Gates BTB update writes so that each committed branch writes the BTB exactly once, even under stalls.
- Sits between the IF stage, the BTB and the EX stage.

Parameters:
- PC_BITS, 20, width of the byte-address PC (word-aligned).
- REFILL_CYCLES, 2, number of bubble cycles after a redirect during which EX results are ignored.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- F_valid  in  1  fetch slot holds a real instruction.
- F_pc  in  PC_BITS  fetch PC.
- F_BP_taken  in  1  BTB predicted taken.
- F_BP_target_pc  in  PC_BITS  BTB predicted next PC.
- F_stall  in  1  front-end stall (holds F/D).
- MEM_stall  in  1  back-end stall (holds F/D/EX).
- EX_brn  in  1  instruction in EX is a branch.
- EX_pc  in  PC_BITS  PC of the EX instruction.
- EX_alu_out  in  PC_BITS  resolved branch target.
- EX_true_taken  in  1  resolved branch direction.
- BTB_upd_en  out  1  qualified BTB write strobe (drives the BTB's EX_brn).
- redirect_valid  out  1  one-cycle PC override to IF.
- redirect_pc  out  PC_BITS  corrected PC.
- flush  out  1  squash F, D and EX this cycle.
- busy  out  1  FSM not IDLE.
- mispred_cnt  out  CNT_W  mispredict count; present only with BP_STATS_EN.
- branch_cnt  out  CNT_W  resolved-branch count; present only with BP_STATS_EN.

Behaviour:
- Meta pipe
  - Two stages, D and EX, each holding {valid, pred_taken, pred_target}.
  - Advance rule: F→D when !F_stall && !MEM_stall; D→EX when !MEM_stall.
  - F_stall with !MEM_stall inserts an invalid entry into EX.
  - flush clears both valid bits.
- Mispredict check, evaluated in IDLE only with ex.valid && !MEM_stall:
  - Branch case: EX_brn && (pred_taken != EX_true_taken || (EX_true_taken && pred_target != EX_alu_out)).
  - Corrected PC for the branch case: EX_alu_out if EX_true_taken, else EX_pc+4.
  - Alias case: !EX_brn && pred_taken. Corrected PC is EX_pc+4.
  - All PC additions wrap modulo 2^PC_BITS.
- FSM states and transitions:
  - IDLE → REDIRECT on a mispredict; redirect_pc is latched at that edge.
  - REDIRECT, one cycle: redirect_valid=1, flush=1. Then → DRAIN, with the counter loaded to REFILL_CYCLES-1.
  - DRAIN: EX checks suppressed and BTB_upd_en=0. Counter decrements each cycle; → IDLE when it reaches 0.
  - If REFILL_CYCLES=0, REDIRECT → IDLE directly.
- Redirect latency: exactly 1 cycle after the EX resolution cycle.
- BTB_upd_en = EX_brn && ex.valid && !MEM_stall && state==IDLE.
  - Exactly one strobe per branch, including a mispredicted branch, whose strobe is in its resolution cycle.
- MEM_stall held: no check and no update. The decision is taken on the first unstalled cycle.
- MEM_stall during REDIRECT or DRAIN does not delay the FSM.
- Simultaneous flush and advance: flush wins, and both valid bits are 0 next cycle.
- Reset values:
  - state = IDLE.
  - Meta valid bits = 0.
  - redirect_valid = 0, redirect_pc = 0, flush = 0, busy = 0, counters = 0.
  - BTB_upd_en = 0 while rst is high.
- Reset mid-REDIRECT or mid-DRAIN: return to IDLE next edge, with no redirect pulse.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: branch_cnt increments on every BTB_upd_en; mispred_cnt increments on every IDLE→REDIRECT. Both counters saturate at all-ones.
- Undefined: the counters and their ports are absent.

Decomposition:
- Package bp_pkg holds:
  - FSM state enum {IDLE, REDIRECT, DRAIN}.
  - bp_meta_t struct {valid, pred_taken, pred_target}.
  - Constant PC_STEP=4.
- One sub-module, bp_meta_pipe: the two-stage stall/flush-aware meta register chain.
- The FSM, compare logic and counters stay in the top module.

Test Plan:
- Correct prediction: F_pc=0x100, F_BP_taken=1, target 0x200, resolved taken with EX_alu_out=0x200 → BTB_upd_en=1 for one cycle, redirect_valid never asserted.
- Direction mispredict: predicted not-taken, resolved taken to 0x340 → redirect_valid=1 and redirect_pc=0x340 one cycle later, flush=1, busy for 1+REFILL_CYCLES cycles.
- Target mispredict and alias: predicted taken to 0x200, resolved taken to 0x280 → redirect to 0x280. Non-branch at 0x0FFFFC predicted taken → redirect_pc=0x000000 (wrap).
- Stall: MEM_stall held 3 cycles with a branch in EX → no BTB_upd_en during the stall, exactly one strobe on release; F_stall alone inserts an invalid EX entry that produces no update.
- Drain suppression and reset: a second mispredicting branch in EX during DRAIN → ignored; rst asserted in REDIRECT → busy=0 and all outputs 0 next cycle.
- BP_STATS_EN: 5 branches with 2 mispredicts → branch_cnt=5, mispred_cnt=2.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM states, prediction metadata and constants for branch_redirect_ctrl.
package bp_pkg;

    localparam int PC_W    = 20;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} bp_state_e;

    typedef struct packed {
        logic            valid;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } bp_meta_t;

endpackage

// File: rtl/bp_meta_pipe.sv
// bp_meta_pipe: carries fetch-time predictions through D and EX, honouring stalls and flush.
module bp_meta_pipe
    import bp_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  bp_meta_t f_meta_i,
    input  logic     f_stall_i,
    input  logic     mem_stall_i,
    input  logic     flush_i,
    output bp_meta_t ex_meta_o
);

    bp_meta_t d_q, ex_q;

    // Flush beats advance; a front-end-only stall holds D and feeds a bubble into EX.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            d_q.valid  <= 1'b0;
            ex_q.valid <= 1'b0;
        end else if (!mem_stall_i) begin
            ex_q <= f_stall_i ? '0 : d_q;
            if (!f_stall_i) d_q <= f_meta_i;
        end
    end

    assign ex_meta_o = ex_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: mispredict detection, registered redirect/flush and BTB write gating.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_redirect_ctrl
    import bp_pkg::*;
#(
    parameter int PC_BITS       = PC_W,
    parameter int REFILL_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               F_valid,
    input  logic [PC_BITS-1:0] F_pc,
    input  logic               F_BP_taken,
    input  logic [PC_BITS-1:0] F_BP_target_pc,
    input  logic               F_stall,
    input  logic               MEM_stall,
    input  logic               EX_brn,
    input  logic [PC_BITS-1:0] EX_pc,
    input  logic [PC_BITS-1:0] EX_alu_out,
    input  logic               EX_true_taken,
    output logic               BTB_upd_en,
    output logic               redirect_valid,
    output logic [PC_BITS-1:0] redirect_pc,
    output logic               flush,
    output logic               busy
`ifdef BP_STATS_EN
    ,
    output logic [CNT_W-1:0]   mispred_cnt,
    output logic [CNT_W-1:0]   branch_cnt
`endif
);

    localparam int RW = REFILL_CYCLES > 1 ? $clog2(REFILL_CYCLES) : 1;

    bp_state_e          state_q;
    logic [RW-1:0]      cnt_q;
    logic               redirect_valid_q, flush_q, busy_q;
    logic [PC_BITS-1:0] redirect_pc_q, redirect_pc_d;
    logic               chk, mispred_d;
    bp_meta_t           f_meta, ex_meta;

    bp_meta_pipe u_meta (
        .clk        (clk),
        .rst        (rst),
        .f_meta_i   (f_meta),
        .f_stall_i  (F_stall),
        .mem_stall_i(MEM_stall),
        .flush_i    (flush_q),
        .ex_meta_o  (ex_meta)
    );

    // Compare the carried prediction with the EX outcome; non-branches predicted taken are aliases.
    always_comb begin
        f_meta        = '{valid: F_valid, pred_taken: F_BP_taken, pred_target: PC_W'(F_BP_target_pc)};
        chk           = state_q == IDLE && ex_meta.valid && !MEM_stall;
        mispred_d     = chk && (EX_brn ? (ex_meta.pred_taken != EX_true_taken ||
                        (EX_true_taken && ex_meta.pred_target != PC_W'(EX_alu_out))) : ex_meta.pred_taken);
        redirect_pc_d = EX_brn && EX_true_taken ? EX_alu_out : EX_pc + PC_BITS'(PC_STEP);
        BTB_upd_en    = !rst && EX_brn && chk;
    end

    // Redirect sequencer: one-cycle redirect/flush, then a drain window ignoring EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (mispred_d) begin
                    state_q          <= REDIRECT;
                    redirect_valid_q <= 1'b1;
                    flush_q          <= 1'b1;
                    busy_q           <= 1'b1;
                    redirect_pc_q    <= redirect_pc_d;
                end
                REDIRECT: begin
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    if (REFILL_CYCLES == 0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DRAIN;
                        cnt_q   <= RW'(REFILL_CYCLES - 1);
                    end
                end
                DRAIN: if (cnt_q == '0) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign busy           = busy_q;

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] mispred_cnt_q, branch_cnt_q;

    // Saturating counts of BTB writes and of redirects launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_cnt_q <= '0;
            branch_cnt_q  <= '0;
        end else begin
            if (mispred_d && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 1'b1;
            if (BTB_upd_en && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
        end
    end

    assign mispred_cnt = mispred_cnt_q;
    assign branch_cnt  = branch_cnt_q;
`endif

endmodule
